// File: rtl/controle_es.sv
// controle_es: board-side I/O sequencing for the single-cycle processor.
// It handles the in, out and halt instructions. For in, it stalls the
// datapath until the operator confirms the switch value with a debounced
// button press. For out, it latches a register value onto the display.
// For halt, it freezes the processor until reset.
module controle_es #(
  parameter int LARGURA         = 32,
  parameter int LARG_CHAVES     = 16,
  parameter int CICLOS_DEBOUNCE = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   OpIn,
  input  logic                   OpOut,
  input  logic                   OpHalt,
  input  logic                   botao,
  input  logic [LARG_CHAVES-1:0] chaves,
  input  logic [LARGURA-1:0]     dado_reg,
  output logic                   Pausa,
  output logic [LARGURA-1:0]     dado_entrada,
  output logic                   escreve_entrada,
  output logic [LARGURA-1:0]     saida,
  output logic                   saida_nova,
  output logic                   aguardando,
  output logic                   parado
);

  localparam int CW = $clog2(CICLOS_DEBOUNCE) + 1;
  // Last count value before the debounced level flips.
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(CICLOS_DEBOUNCE - 1);

  localparam logic [2:0] EXECUTA       = 3'd0;
  localparam logic [2:0] ESPERA_SOLTAR = 3'd1;
  localparam logic [2:0] ESPERA_APERTO = 3'd2;
  localparam logic [2:0] CAPTURA       = 3'd3;
  localparam logic [2:0] PARADO        = 3'd4;

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               bd_q, bd_d;
  logic [2:0]         estado_q, estado_d;
  logic [LARGURA-1:0] saida_q, saida_d;
  logic               saida_nova_q, saida_nova_d;
  logic [LARGURA-1:0] dado_q, dado_d;
  logic [LARGURA-1:0] chaves_ext;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_comb begin
    sync1_d = botao;
    sync2_d = sync1_q;
  end

  // Debounce: the level must differ from bd for CICLOS_DEBOUNCE consecutive cycles.
  always_comb begin
    cnt_d = '0;
    bd_d  = bd_q;
    if (sync2_q != bd_q) begin
      if (cnt_q == CNT_ULTIMO) begin
        bd_d = ~bd_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Zero-extend the switch bank to the datapath width.
  always_comb begin
    chaves_ext                  = '0;
    chaves_ext[LARG_CHAVES-1:0] = chaves;
  end

  // Instruction sequencing. Halt has priority over in, and in over out.
  always_comb begin
    estado_d     = estado_q;
    saida_d      = saida_q;
    saida_nova_d = 1'b0;
    dado_d       = dado_q;
    case (estado_q)
      EXECUTA: begin
        if (OpHalt) begin
          estado_d = PARADO;
        end else if (OpIn) begin
          estado_d = ESPERA_SOLTAR;
        end else if (OpOut) begin
          saida_d      = dado_reg;
          saida_nova_d = 1'b1;
        end
      end
      // A button still held from before must be released first.
      ESPERA_SOLTAR: if (!bd_q) estado_d = ESPERA_APERTO;
      ESPERA_APERTO: begin
        if (bd_q) begin
          dado_d   = chaves_ext;
          estado_d = CAPTURA;
        end
      end
      // OpIn is still high here for the same instruction and is ignored.
      CAPTURA: estado_d = EXECUTA;
      PARADO:  estado_d = PARADO;
      default: estado_d = EXECUTA;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      bd_q         <= 1'b0;
      estado_q     <= EXECUTA;
      saida_q      <= '0;
      saida_nova_q <= 1'b0;
      dado_q       <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      bd_q         <= bd_d;
      estado_q     <= estado_d;
      saida_q      <= saida_d;
      saida_nova_q <= saida_nova_d;
      dado_q       <= dado_d;
    end
  end

  // Pausa is combinational so in/halt stall in their own first cycle. It is
  // forced low while reset is asserted.
  always_comb begin
    Pausa = ~reset & (((estado_q == EXECUTA) & (OpIn | OpHalt)) |
                      (estado_q == ESPERA_SOLTAR) |
                      (estado_q == ESPERA_APERTO) |
                      (estado_q == PARADO));
  end

  assign escreve_entrada = (estado_q == CAPTURA);
  assign aguardando      = (estado_q == ESPERA_SOLTAR) | (estado_q == ESPERA_APERTO);
  assign parado          = (estado_q == PARADO);
  assign saida           = saida_q;
  assign saida_nova      = saida_nova_q;
  assign dado_entrada    = dado_q;

endmodule

// File: tb/tb_controle_es.sv
// Testbench for controle_es: directed scenarios plus randomized instruction
// and button traffic, all checked against a behavioural model.
module tb_controle_es;

  localparam int LARGURA = 32;
  localparam int LARG_CHAVES = 16;
  localparam int C = 4;

  localparam int M_EXEC   = 0;
  localparam int M_SOLTAR = 1;
  localparam int M_APERTO = 2;
  localparam int M_CAPT   = 3;
  localparam int M_HALT   = 4;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   OpIn = 1'b0, OpOut = 1'b0, OpHalt = 1'b0, botao = 1'b0;
  logic [LARG_CHAVES-1:0] chaves = '0;
  logic [LARGURA-1:0]     dado_reg = '0;
  logic                   Pausa, escreve_entrada, saida_nova, aguardando, parado;
  logic [LARGURA-1:0]     dado_entrada, saida;

  controle_es #(
    .LARGURA(LARGURA), .LARG_CHAVES(LARG_CHAVES), .CICLOS_DEBOUNCE(C)
  ) dut (
    .clock(clock), .reset(reset), .OpIn(OpIn), .OpOut(OpOut), .OpHalt(OpHalt),
    .botao(botao), .chaves(chaves), .dado_reg(dado_reg), .Pausa(Pausa),
    .dado_entrada(dado_entrada), .escreve_entrada(escreve_entrada),
    .saida(saida), .saida_nova(saida_nova), .aguardando(aguardando), .parado(parado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          m_st;
  logic        m_bd;
  logic [31:0] m_saida, m_dado;
  logic        m_nova;
  logic        sq[$];     // botao samples taken at past rising edges, oldest first
  int          halt_len = 0;

  // Last observed outputs, for directed checks
  logic        obs_pausa, obs_escreve, obs_nova, obs_aguard, obs_parado;
  logic [31:0] obs_saida, obs_dado;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_EXEC;
    m_bd = 1'b0;
    m_saida = '0;
    m_dado = '0;
    m_nova = 1'b0;
    sq.delete();
    for (int i = 0; i < C + 2; i++) sq.push_back(1'b0);
  endtask

  // One rising edge of the model. The debounced level flips once the button,
  // seen two samples late through the synchronizer, has disagreed with it
  // for C consecutive edges.
  task automatic model_edge();
    logic tog;
    int   nst;
    logic nnova;
    tog = 1'b1;
    for (int j = 2; j <= C + 1; j++) begin
      if (sq[C + 2 - j] == m_bd) tog = 1'b0;
    end
    nst = m_st;
    nnova = 1'b0;
    case (m_st)
      M_EXEC: begin
        if (OpHalt) begin
          nst = M_HALT;
          $display("halt");
        end else if (OpIn) begin
          nst = M_SOLTAR;
        end else if (OpOut) begin
          m_saida = dado_reg;
          nnova = 1'b1;
          $display("out  saida=%h", dado_reg);
        end
      end
      M_SOLTAR: if (!m_bd) nst = M_APERTO;
      M_APERTO: begin
        if (m_bd) begin
          m_dado = {16'h0000, chaves};
          nst = M_CAPT;
          $display("in   dado=%h", m_dado);
        end
      end
      M_CAPT: nst = M_EXEC;
      default: nst = m_st;
    endcase
    m_st = nst;
    m_nova = nnova;
    if (tog) m_bd = ~m_bd;
    sq.push_back(botao);
    void'(sq.pop_front());
  endtask

  task automatic check_outputs();
    logic exp_pausa;
    exp_pausa = (m_st == M_EXEC && (OpIn || OpHalt)) || m_st == M_SOLTAR ||
                m_st == M_APERTO || m_st == M_HALT;
    chk("pausa", 64'(Pausa), 64'(exp_pausa));
    chk("escreve", 64'(escreve_entrada), 64'(m_st == M_CAPT));
    chk("aguardando", 64'(aguardando), 64'(m_st == M_SOLTAR || m_st == M_APERTO));
    chk("parado", 64'(parado), 64'(m_st == M_HALT));
    chk("saida", 64'(saida), 64'(m_saida));
    chk("saida_nova", 64'(saida_nova), 64'(m_nova));
    chk("dado_entrada", 64'(dado_entrada), 64'(m_dado));
    obs_pausa = Pausa;
    obs_escreve = escreve_entrada;
    obs_nova = saida_nova;
    obs_aguard = aguardando;
    obs_parado = parado;
    obs_saida = saida;
    obs_dado = dado_entrada;
  endtask

  // Drive one cycle of inputs (entered and left at a falling edge).
  task automatic step(input logic i_in, input logic i_out, input logic i_halt,
                      input logic i_bot, input logic [15:0] i_ch, input logic [31:0] i_dr);
    OpIn = i_in;
    OpOut = i_out;
    OpHalt = i_halt;
    botao = i_bot;
    chaves = i_ch;
    dado_reg = i_dr;
    #1;
    check_outputs();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  // Assert reset mid-cycle with strobes high; every output must drop at once.
  task automatic do_reset();
    OpOut = 1'b1;
    OpIn = 1'b1;
    dado_reg = 32'hDEADBEEF;
    #3;
    reset = 1'b1;
    #1;
    chk("rst_pausa", 64'(Pausa), 64'(0));
    chk("rst_escreve", 64'(escreve_entrada), 64'(0));
    chk("rst_aguardando", 64'(aguardando), 64'(0));
    chk("rst_parado", 64'(parado), 64'(0));
    chk("rst_saida", 64'(saida), 64'(0));
    chk("rst_saida_nova", 64'(saida_nova), 64'(0));
    chk("rst_dado", 64'(dado_entrada), 64'(0));
    model_reset();
    halt_len = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    OpOut = 1'b0;
    OpIn = 1'b0;
  endtask

  // Hold the button pressed with OpIn high until one capture is seen.
  task automatic press(input logic [15:0] ch, output int lat, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    lat = -1;
    for (int m = 0; m < 15; m++) begin
      step(!got, 1'b0, 1'b0, 1'b1, ch, 32'h0);
      if (obs_escreve) begin
        n++;
        if (lat < 0) lat = m;
        chk("cap_dado", 64'(obs_dado), 64'({16'h0000, ch}));
        chk("cap_pausa", 64'(obs_pausa), 64'(0));
        got = 1'b1;
      end
    end
  endtask

  initial begin
    int lat, n;
    int seg_left;
    logic seg_lvl;
    seg_left = 0;
    seg_lvl = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Reset while an out is pending clears the display register.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h00001234);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("pre_rst_saida", 64'(obs_saida), 64'(32'h00001234));
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("post_rst_saida", 64'(obs_saida), 64'(0));

    // out: one-cycle latency, one-cycle strobe, never stalls.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0000002A);
    chk("out_no_stall", 64'(obs_pausa), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("out_saida", 64'(obs_saida), 64'(32'h0000002A));
    chk("out_nova", 64'(obs_nova), 64'(1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("out_nova_drop", 64'(obs_nova), 64'(0));

    // Clean in: released button, then a press.
    for (int m = 0; m < 10; m++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, 32'h0);
      if (m == 0) chk("in_first_stall", 64'(obs_pausa), 64'(1));
    end
    press(16'h00FF, lat, n);
    chk("in_latency", 64'(lat), 64'(7));
    chk("in_count", 64'(n), 64'(1));
    for (int m = 0; m < 8; m++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Button already held when in starts must not confirm.
    for (int m = 0; m < 8; m++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0);
    for (int m = 0; m < 10; m++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 16'hA5A5, 32'h0);
      chk("held_no_cap", 64'(obs_escreve), 64'(0));
      if (m > 0) chk("held_aguard", 64'(obs_aguard), 64'(1));
    end
    for (int m = 0; m < 8; m++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'hA5A5, 32'h0);
    press(16'hA5A5, lat, n);
    chk("held_count", 64'(n), 64'(1));
    for (int m = 0; m < 8; m++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Bouncing button: 2-cycle pulses never reach the debounced level.
    for (int m = 0; m < 3; m++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0);
    for (int m = 0; m < 20; m++) begin
      step(1'b1, 1'b0, 1'b0, ((m / 2) % 2) == 0, 16'h1234, 32'h0);
      chk("bounce_aguard", 64'(obs_aguard), 64'(1));
      chk("bounce_no_cap", 64'(obs_escreve), 64'(0));
    end
    press(16'h1234, lat, n);
    chk("bounce_count", 64'(n), 64'(1));
    for (int m = 0; m < 8; m++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Halt: stalls immediately, ignores all strobes, and only reset leaves it.
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0);
    chk("halt_stall", 64'(obs_pausa), 64'(1));
    for (int m = 0; m < 6; m++) begin
      step(m[0], ~m[0], 1'b0, 1'b1, 16'hFFFF, 32'h55555555);
      chk("halt_parado", 64'(obs_parado), 64'(1));
      chk("halt_saida", 64'(obs_saida), 64'(32'h0000002A));
    end
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("halt_cleared", 64'(obs_parado), 64'(0));

    // Randomized traffic: strobes follow a processor-like program flow.
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic r_in, r_out, r_halt;
      int r;
      if (seg_left == 0) begin
        seg_lvl = ($urandom_range(0, 1) == 1);
        seg_left = $urandom_range(1, 10);
      end
      seg_left--;
      if (m_st != M_EXEC && $urandom_range(0, 149) == 0) begin
        do_reset();
        continue;
      end
      if (m_st == M_HALT) begin
        halt_len++;
        if (halt_len > 8) begin
          do_reset();
          continue;
        end
        r_in = ($urandom_range(0, 1) == 1);
        r_out = ($urandom_range(0, 1) == 1);
        r_halt = ($urandom_range(0, 1) == 1);
      end else if (m_st == M_EXEC) begin
        r = $urandom_range(0, 99);
        r_halt = (r < 2);
        r_in = (r < 22);
        r_out = (r >= 15 && r < 60);
      end else begin
        r_in = 1'b1;
        r_out = 1'b0;
        r_halt = 1'b0;
      end
      step(r_in, r_out, r_halt, seg_lvl, 16'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_es.md
# controle_es

I/O sequencing controller for the single-cycle processor. It consumes the `OpIn`, `OpOut` and `OpHalt` decode strobes from the control unit and carries out the board-side half of those instructions. For `in`, it stalls the datapath until the operator confirms a switch value with a debounced button press, then delivers that value for a one-cycle register write. For `out`, it latches a register value to the display. For `halt`, it freezes the processor until reset.

## Interface
Parameters:
- `LARGURA`, 32: datapath word width.
- `LARG_CHAVES`, 16: number of input switches; must be ≤ `LARGURA`.
- `CICLOS_DEBOUNCE`, 4: consecutive stable cycles required before the button level is accepted; the board build overrides this to 50000.

Ports:
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `OpIn`  in  1: decode strobe for the `in` instruction.
- `OpOut`  in  1: decode strobe for the `out` instruction.
- `OpHalt`  in  1: decode strobe for the `halt` instruction.
- `botao`  in  1: raw confirm pushbutton, active-high, asynchronous to `clock`.
- `chaves`  in  `LARG_CHAVES`: raw switch bank.
- `dado_reg`  in  `LARGURA`: value read from the register file for `out`.
- `Pausa`  out  1: when 1, PC holds, and register and memory writes are suppressed.
- `dado_entrada`  out  `LARGURA`: captured switch value, zero-extended.
- `escreve_entrada`  out  1: one-cycle strobe that writes `dado_entrada` into the destination register.
- `saida`  out  `LARGURA`: display register.
- `saida_nova`  out  1: one-cycle strobe, high in the cycle after `saida` is updated.
- `aguardando`  out  1: waiting-for-input LED.
- `parado`  out  1: halted LED.

## Operation
- Button conditioning:
  - `botao` passes through a 2-flop synchronizer.
  - Counter `cnt`, width `$clog2(CICLOS_DEBOUNCE)+1`:
    - Increments each cycle that the synchronized level differs from debounced level `bd`.
    - Clears on any cycle where they are equal.
    - On the cycle it would reach `CICLOS_DEBOUNCE`, `bd` toggles and `cnt` clears.
  - Glitches shorter than `CICLOS_DEBOUNCE` cycles never reach `bd`.
- States: `EXECUTA`, `ESPERA_SOLTAR`, `ESPERA_APERTO`, `CAPTURA`, `PARADO`.
- `EXECUTA`, when multiple strobes are high, priority is `OpHalt` > `OpIn` > `OpOut`:
  - `OpHalt`=1 → go to `PARADO`.
  - `OpIn`=1 → go to `ESPERA_SOLTAR`.
  - `OpOut`=1 → `saida` <= `dado_reg` and `saida_nova` <= 1; remain in `EXECUTA`.
- `ESPERA_SOLTAR`: when `bd`=0, go to `ESPERA_APERTO`. A button already held when `in` executes never auto-confirms.
- `ESPERA_APERTO`: when `bd`=1, `dado_entrada` <= zero-extended `chaves` sampled on that edge, then go to `CAPTURA`.
- `CAPTURA`: unconditionally go to `EXECUTA`. `OpIn` is still 1 here (same instruction) and is ignored.
- `PARADO`: absorbing; only reset leaves it. All strobes are ignored.
- Outputs:
  - `Pausa` = (`EXECUTA` & (`OpIn` | `OpHalt`)) | `ESPERA_SOLTAR` | `ESPERA_APERTO` | `PARADO`. Combinational, so the `in`/`halt` instruction stalls in its own first cycle.
  - `escreve_entrada` = `CAPTURA`. `Pausa` is 0 in `CAPTURA`, so the write commits and PC advances on that edge.
  - `aguardando` = `ESPERA_SOLTAR` | `ESPERA_APERTO`.
  - `parado` = `PARADO`.
- `dado_entrada` and `saida` hold their values until the next capture or `out`.

## Timing
- Reset, asynchronous: state = `EXECUTA`; `saida`, `dado_entrada`, `cnt`, `bd` and the sync flops = 0; `saida_nova` = 0. All outputs read 0 while `reset` is high, including `Pausa`.
- Reset mid-wait (`ESPERA_*`) or in `PARADO` returns to `EXECUTA` immediately. No `escreve_entrada` pulse is produced.
- `out`: 1-cycle latency. `saida` and `saida_nova` are valid the cycle after the `OpOut` edge. Never stalls. Back-to-back `out` instructions update every cycle, with `saida_nova` high each cycle.
- `in` with the button initially released, and `botao` rising at edge t after `ESPERA_APERTO` is entered:
  - Synchronized level rises at t+2.
  - `bd` rises at t+2+`CICLOS_DEBOUNCE`.
  - Next edge: capture; `CAPTURA` is active and `escreve_entrada`=1 for exactly one cycle.
  - Minimum `in` duration = 2 + `CICLOS_DEBOUNCE` + 2 cycles after entry.
- `botao` is sampled only through the synchronizer. `chaves` is sampled directly at capture; the operator keeps it stable while pressing.

## Test plan
- Reset: assert `reset` mid-cycle with `OpOut`=1 → all outputs 0 immediately; after release, `saida`=0 and the state is `EXECUTA`.
- `out`: `dado_reg`=0x0000002A with `OpOut` pulsed for 1 cycle → next cycle `saida`=0x0000002A and `saida_nova`=1 for one cycle; `Pausa` stays 0 throughout.
- Clean `in`: `OpIn` held, `chaves`=16'h00FF, `botao` low for 10 cycles then high → `Pausa`=1 from the first cycle; `escreve_entrada` pulses once, 7 cycles after `botao` rises, with `dado_entrada`=0x000000FF; `Pausa`=0 in that cycle.
- Held button: `botao`=1 before `OpIn` asserts → no capture while held; release for ≥4 cycles, press again → single capture.
- Bounce: `botao` toggles in 2-cycle pulses for 20 cycles → `bd` never rises, no capture, `aguardando`=1 throughout.
- Halt: `OpHalt`=1 → `Pausa`=`parado`=1 from that cycle; subsequent `OpIn`/`OpOut` have no effect and `saida` is unchanged; `reset` returns the block to `EXECUTA` with `parado`=0.
